// File: rtl/ysyx_25040105_seq_ctrl.sv
// ysyx_25040105_seq_ctrl: multi-cycle instruction sequencer for the NPC core.
// Owns PC and the instruction register. Runs fetch, decode, execute, an
// optional memory access and writeback. Stops on ebreak (halt) or on a
// response timeout / misaligned next_pc (fault).
// Optional macro PERF_CNT_EN adds 64-bit cycle and retired-instruction
// counters. Without it, both counter outputs are tied to zero.
module ysyx_25040105_seq_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        ifu_req_valid,
  input  logic        ifu_req_ready,
  output logic [31:0] ifu_req_addr,
  input  logic        ifu_rsp_valid,
  output logic        ifu_rsp_ready,
  input  logic [31:0] ifu_rsp_data,
  output logic [31:0] inst,
  output logic [31:0] pc,
  input  logic        dec_is_load,
  input  logic        dec_is_store,
  input  logic        dec_is_ebreak,
  input  logic        dec_reg_wen,
  input  logic [31:0] next_pc,
  output logic        lsu_req_valid,
  input  logic        lsu_req_ready,
  output logic        lsu_we,
  input  logic        lsu_rsp_valid,
  output logic        lsu_rsp_ready,
  output logic        rf_wen,
  output logic        retire,
  output logic        halt,
  output logic        fault,
  output logic [63:0] cycle_cnt,
  output logic [63:0] inst_cnt
);

  typedef enum logic [3:0] {
    S_FETCH_REQ,
    S_FETCH_WAIT,
    S_DECODE,
    S_EXEC,
    S_MEM_REQ,
    S_MEM_WAIT,
    S_WB,
    S_HALT,
    S_FAULT
  } state_e;

  // The last wait cycle that may still accept a response.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [15:0] tmo_q, tmo_d;
  logic        wb_ok;

  assign wb_ok = (state_q == S_WB) && (next_pc[1:0] == 2'b00);

  // State, PC, instruction and timeout registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH_REQ;
      pc_q    <= RESET_PC;
      inst_q  <= 32'h0000_0013;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      tmo_q   <= tmo_d;
    end
  end

  // Next-state logic. Responses are only taken in the WAIT states.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    tmo_d   = tmo_q;
    case (state_q)
      S_FETCH_REQ: begin
        if (ifu_req_ready) begin
          state_d = S_FETCH_WAIT;
          tmo_d   = '0;
        end
      end
      S_FETCH_WAIT: begin
        if (ifu_rsp_valid) begin
          inst_d  = ifu_rsp_data;
          state_d = S_DECODE;
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_FAULT;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (dec_is_ebreak)                    state_d = S_HALT;
        else if (dec_is_load || dec_is_store) state_d = S_MEM_REQ;
        else                                  state_d = S_WB;
      end
      S_MEM_REQ: begin
        if (lsu_req_ready) begin
          state_d = S_MEM_WAIT;
          tmo_d   = '0;
        end
      end
      S_MEM_WAIT: begin
        if (lsu_rsp_valid)            state_d = S_WB;
        else if (tmo_q == TMO_LAST)   state_d = S_FAULT;
        else                          tmo_d = tmo_q + 16'd1;
      end
      S_WB: begin
        if (next_pc[1:0] != 2'b00) begin
          state_d = S_FAULT;
        end else begin
          pc_d    = next_pc;
          state_d = S_FETCH_REQ;
        end
      end
      S_HALT:  state_d = S_HALT;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FAULT;
    endcase
  end

  // The fetch request is gated by rst_n so nothing is offered while in reset.
  assign ifu_req_valid = rst_n && (state_q == S_FETCH_REQ);
  assign ifu_req_addr  = pc_q;
  assign ifu_rsp_ready = (state_q == S_FETCH_WAIT);
  assign lsu_req_valid = (state_q == S_MEM_REQ);
  assign lsu_we        = (state_q == S_MEM_REQ) && dec_is_store;
  assign lsu_rsp_ready = (state_q == S_MEM_WAIT);
  assign rf_wen        = wb_ok && dec_reg_wen;
  // ebreak retires on the cycle that commits the move into HALT.
  assign retire        = wb_ok || ((state_q == S_EXEC) && dec_is_ebreak);
  assign halt          = (state_q == S_HALT);
  assign fault         = (state_q == S_FAULT);
  assign inst          = inst_q;
  assign pc            = pc_q;

`ifdef PERF_CNT_EN
  logic [63:0] cyc_q, icnt_q;

  // Free-running perf counters, frozen once the core has stopped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q  <= '0;
      icnt_q <= '0;
    end else begin
      if (!halt && !fault) cyc_q <= cyc_q + 64'd1;
      if (retire)          icnt_q <= icnt_q + 64'd1;
    end
  end

  assign cycle_cnt = cyc_q;
  assign inst_cnt  = icnt_q;
`else
  assign cycle_cnt = 64'd0;
  assign inst_cnt  = 64'd0;
`endif

endmodule

// File: doc/ysyx_25040105_seq_ctrl.md
Name: ysyx_25040105_seq_ctrl

Overview:
Multi-cycle sequencer for the NPC core. It owns the PC and instruction registers and issues fetch requests over a valid/ready handshake. It sequences decode, execute, optional memory access and writeback for the combinational decoder/ALU datapath. It gates register-file writes to exactly one cycle per retired instruction and stops the core on ebreak or a bus fault.

Parameters:
RESET_PC, 32'h8000_0000, PC value loaded on reset
TIMEOUT, 255, max cycles spent waiting for a response before a fault (range 1..65535)

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
ifu_req_valid  out  1  fetch request valid
ifu_req_ready  in  1  fetch request accepted
ifu_req_addr  out  32  fetch address (= pc)
ifu_rsp_valid  in  1  fetch data valid
ifu_rsp_ready  out  1  sequencer can take fetch data
ifu_rsp_data  in  32  fetched instruction
inst  out  32  latched instruction, drives decoder
pc  out  32  current PC
dec_is_load  in  1  decoder: load
dec_is_store  in  1  decoder: store
dec_is_ebreak  in  1  decoder: ebreak
dec_reg_wen  in  1  decoder: instruction writes rd
next_pc  in  32  EXU-computed next PC
lsu_req_valid  out  1  memory request valid
lsu_req_ready  in  1  memory request accepted
lsu_we  out  1  1 = store, 0 = load; held with lsu_req_valid
lsu_rsp_valid  in  1  load data / store ack valid
lsu_rsp_ready  out  1  sequencer can take response
rf_wen  out  1  register-file write strobe
retire  out  1  one-cycle pulse per retired instruction
halt  out  1  sticky: ebreak executed
fault  out  1  sticky: timeout or misaligned next_pc
cycle_cnt  out  64  perf: cycles since reset
inst_cnt  out  64  perf: retired instructions

Behaviour:
- Reset (async, rst_n=0): state=FETCH_REQ, pc=RESET_PC, inst=32'h0000_0013 (nop), timeout counter=0, halt=0, fault=0, counters=0. All request/strobe outputs deassert immediately, including mid-handshake.
- States and transitions:
  - FETCH_REQ: ifu_req_valid=1, ifu_req_addr=pc, held stable until accepted. ifu_req_ready=1 -> FETCH_WAIT.
  - FETCH_WAIT: ifu_rsp_ready=1. ifu_rsp_valid=1 -> inst<=ifu_rsp_data, go to DECODE.
  - DECODE: 1 cycle, decoder settles on inst -> EXEC.
  - EXEC: 1 cycle. Priority order: dec_is_ebreak -> HALT; else load/store -> MEM_REQ; else -> WB.
  - MEM_REQ: lsu_req_valid=1, lsu_we=dec_is_store, held stable until accepted. lsu_req_ready=1 -> MEM_WAIT.
  - MEM_WAIT: lsu_rsp_ready=1. lsu_rsp_valid=1 -> WB. Store also waits for ack.
  - WB: 1 cycle. If next_pc[1:0]!=0 -> FAULT; pc unchanged, rf_wen=0, no retire. Else rf_wen=dec_reg_wen, retire=1, pc<=next_pc, go to FETCH_REQ.
  - HALT: halt=1, ebreak counts as retired (retire pulse on entry); pc unchanged. Terminal until reset.
  - FAULT: fault=1. Terminal until reset.
- Latency: ALU instruction with zero-wait memory = 5 cycles request-to-request (FETCH_REQ, FETCH_WAIT, DECODE, EXEC, WB). Load/store = 7 cycles.
- rf_wen is asserted only in WB and never in HALT or FAULT.
- Same-cycle req_ready and rsp_valid: the response is ignored in the REQ state and must be re-presented in the WAIT state.
- Timeout: counter cleared on entry to FETCH_WAIT/MEM_WAIT, increments each cycle without rsp_valid. Reaching TIMEOUT -> FAULT. A response arriving in the same cycle as the timeout wins (no fault).
- Responses outside the WAIT states are ignored (rsp_ready=0).

Optional Feature:
PERF_CNT_EN: when defined, cycle_cnt increments every cycle except in HALT/FAULT, and inst_cnt increments on each retire pulse. Both are 64-bit and wrap to 0. When undefined, both outputs are tied to 0 and no counter flops exist.

Test Plan:
- Reset, ifu_req_ready=1, 0-wait responses, addi stream -> ifu_req_addr=0x80000000, then 0x80000004, with request-to-request spacing of 5 cycles; one rf_wen per instruction.
- Load with lsu_req_ready delayed 3 cycles -> lsu_req_valid held 4 cycles with stable lsu_we=0; rf_wen=1 exactly one cycle after lsu_rsp_valid.
- Store -> lsu_we=1, rf_wen=0 in WB (dec_reg_wen=0), retire=1, pc+=4.
- ebreak at 0x80000008 -> halt=1, pc stays 0x80000008, no further ifu_req_valid; with PERF_CNT_EN, inst_cnt=3 and frozen.
- ifu_rsp_valid never asserted, TIMEOUT=255 -> fault=1 after 255 wait cycles; response at exactly cycle 255 -> no fault.
- rst_n dropped mid MEM_REQ -> lsu_req_valid=0 immediately, pc=0x80000000 on release; next_pc=0x80000002 in WB -> fault=1, pc unchanged.
